barcode_rx: RTL and testbench

//  Decodes the serial barcode stream on pin BC into an 8-bit station ID for the Follower's command/control logic.

---
 rtl/follower_pkg.sv | 22 ++
 rtl/barcode_rx_sync_edge.sv | 36 +++
 rtl/barcode_rx.sv | 128 ++++++++++++
 tb/tb_barcode_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/follower_pkg.sv
// Shared types for the Follower barcode receiver.
//   bc_state_t : FSM states of barcode_rx
//   BC_ID_BITS : station-ID width carried by one barcode frame
//   bc_id_ok() : frame acceptance test (station IDs never use the two MSBs)
package follower_pkg;

  localparam int BC_ID_BITS = 8;

  typedef enum logic [2:0] {
    BC_IDLE,
    BC_START,
    BC_WAIT_FALL,
    BC_SAMPLE,
    BC_DONE
  } bc_state_t;

  // Frames whose two MSBs are not 00 are corrupt reads and are dropped.
  function automatic logic bc_id_ok(input logic [BC_ID_BITS-1:0] id);
    return id[BC_ID_BITS-1 -: 2] == 2'b00;
  endfunction

endpackage

// File: rtl/barcode_rx_sync_edge.sv
// bc_sync_edge: brings the asynchronous BC line into the clk domain and
// flags its edges.
//   clk, rst_n : clock, synchronous active-low reset
//   i_bc       : raw barcode line (idle high)
//   o_bc_s     : synchronized level
//   o_bc_fall  : 1-clk pulse, synchronized level went 1->0
//   o_bc_rise  : 1-clk pulse, synchronized level went 0->1
module bc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_bc,
  output logic o_bc_s,
  output logic o_bc_fall,
  output logic o_bc_rise
);

  logic r_meta, r_sync, r_prev;

  // Preset high so reset release does not look like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_bc;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_bc_s    = r_sync;
  assign o_bc_fall = r_prev & ~r_sync;
  assign o_bc_rise = ~r_prev & r_sync;

endmodule

// File: rtl/barcode_rx.sv
// barcode_rx: decodes the serial barcode on BC into an 8-bit station ID.
// The start pulse low time S calibrates the sampler: each data bit starts
// with a falling edge and its value is the line level S clk later.
//   clk, rst_n  : clock, synchronous active-low reset
//   BC          : raw barcode line, idle high
//   clr_ID_vld  : consumer acknowledge, clears ID_vld
//   ID          : last accepted station ID
//   ID_vld      : ID holds a new accepted value (held until cleared)
//   busy        : a frame is in progress
module barcode_rx
  import follower_pkg::*;
#(
  parameter int               CNT_W     = 22,
  parameter logic [CNT_W-1:0] TIMEOUT   = 22'h3FFFFF,
  parameter int               MIN_START = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  BC,
  input  logic                  clr_ID_vld,
  output logic [BC_ID_BITS-1:0] ID,
  output logic                  ID_vld,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_bc_s, w_fall, w_rise;

  bc_state_t             r_state;
  logic [CNT_W-1:0]      r_pulse_cnt, r_smp_cnt, r_idle_cnt, r_s;
  logic [3:0]            r_bit_cnt;
  logic [BC_ID_BITS-1:0] r_shreg, r_id;
  logic                  r_id_vld;

  bc_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bc     (BC),
    .o_bc_s   (w_bc_s),
    .o_bc_fall(w_fall),
    .o_bc_rise(w_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= BC_IDLE;
      r_pulse_cnt <= '0;
      r_smp_cnt   <= '0;
      r_idle_cnt  <= '0;
      r_s         <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_id        <= '0;
      r_id_vld    <= 1'b0;
    end else begin
      // A DONE-state set below overrides this clear in the same cycle.
      if (clr_ID_vld) r_id_vld <= 1'b0;

      unique case (r_state)
        BC_IDLE: begin
          r_bit_cnt <= '0;
          r_shreg   <= '0;
          if (w_fall) begin
            r_pulse_cnt <= CNT_W'(1);
            r_state     <= BC_START;
          end
        end

        BC_START: begin
          if (w_rise) begin
            if (r_pulse_cnt < CNT_W'(MIN_START)) begin
              r_state <= BC_IDLE;            // glitch, not a start pulse
            end else begin
              r_s        <= r_pulse_cnt;
              r_idle_cnt <= '0;
              r_state    <= BC_WAIT_FALL;
            end
          end else begin
            r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
            // Counter about to saturate: line is stuck low.
            if (r_pulse_cnt == CNT_MAX - CNT_W'(1)) r_state <= BC_IDLE;
          end
        end

        BC_WAIT_FALL: begin
          r_idle_cnt <= r_idle_cnt + CNT_W'(1);
          if (w_fall) begin
            r_smp_cnt <= CNT_W'(1);
            r_state   <= BC_SAMPLE;
          end else if (r_idle_cnt == TIMEOUT) begin
            r_state <= BC_IDLE;
          end
        end

        BC_SAMPLE: begin
          // Edges are ignored here; only the S-clk sample point matters.
          r_smp_cnt <= r_smp_cnt + CNT_W'(1);
          if (r_smp_cnt == r_s) begin
            r_shreg   <= {r_shreg[BC_ID_BITS-2:0], w_bc_s};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'(BC_ID_BITS - 1)) begin
              r_state <= BC_DONE;
            end else begin
              r_idle_cnt <= '0;
              r_state    <= BC_WAIT_FALL;
            end
          end
        end

        BC_DONE: begin
          if (bc_id_ok(r_shreg)) begin
            r_id     <= r_shreg;
            r_id_vld <= 1'b1;
          end
          r_state <= BC_IDLE;
        end

        default: r_state <= BC_IDLE;
      endcase
    end
  end

  assign ID     = r_id;
  assign ID_vld = r_id_vld;
  assign busy   = (r_state != BC_IDLE);

endmodule

// File: tb/tb_barcode_rx.sv
// Directed bench for barcode_rx. Frames follow the barcode_mimic timing:
// period P, start low P/2, bit '1' low P/4, bit '0' low 3P/4, so the
// sample point P/2 after each falling edge sits mid-way between the two.
// A second instance with TIMEOUT=1000 covers the frame-abort path.
module tb_barcode_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       BC = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] id, id2;
  logic       vld, vld2, busy, busy2;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  barcode_rx u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BC        (BC),
    .clr_ID_vld(clr),
    .ID        (id),
    .ID_vld    (vld),
    .busy      (busy)
  );

  barcode_rx #(.TIMEOUT(22'd1000)) u_dut_to (
    .clk       (clk),
    .rst_n     (rst_n),
    .BC        (BC),
    .clr_ID_vld(clr),
    .ID        (id2),
    .ID_vld    (vld2),
    .busy      (busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_start(input int p);
    for (int c = 0; c < p; c++) begin
      BC = (c < p / 2) ? 1'b0 : 1'b1;
      tick;
    end
  endtask

  // clr_at: slot cycle on which clr_ID_vld is driven (-1 = never).
  // lat_at: slot cycle at which the 8th-sample latency is checked (-1 = off).
  task automatic send_bit(input logic b, input int p, input int clr_at, input int lat_at);
    int low;
    low = b ? p / 4 : (3 * p) / 4;
    for (int c = 0; c < p; c++) begin
      BC  = (c < low) ? 1'b0 : 1'b1;
      clr = (c == clr_at);
      tick;
      if (lat_at >= 0 && c == lat_at) begin
        chk("lat_pre_vld", 32'(vld), 32'd0);
        chk("lat_pre_busy", 32'(busy), 32'd1);
      end
      if (lat_at >= 0 && c == lat_at + 1) begin
        chk("lat_vld", 32'(vld), 32'd1);
        chk("lat_busy", 32'(busy), 32'd0);
      end
    end
    clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fid, input int p, input int clr_at, input int lat_at);
    send_start(p);
    for (int i = 7; i >= 0; i--)
      send_bit(fid[i], p, (i == 0) ? clr_at : -1, (i == 0) ? lat_at : -1);
    BC = 1'b1;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  task automatic pulse_rst;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic glitch(input int n, input string tag);
    BC = 1'b0;
    repeat (n) tick;
    BC = 1'b1;
    repeat (10) tick;
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rid;
    int         p;

    // Reset state
    repeat (3) tick;
    chk("rst_id", 32'(id), 32'h00);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick;

    // 1: period 0x20a (S=261), ID ready 1 clk after the 8th sample
    send_frame(8'h25, 16'h20a, -1, 16'h20a / 2 + 2);
    chk("t1_id", 32'(id), 32'h25);
    chk("t1_busy", 32'(busy), 32'd0);

    // 3a: acknowledge clears ID_vld on the next clk
    chk("t3_vld_before", 32'(vld), 32'd1);
    pulse_clr;
    chk("t3_clr", 32'(vld), 32'd0);

    // 2: upper bits 11 dropped, then a good frame
    send_frame(8'hC5, 100, -1, -1);
    chk("t2_bad_vld", 32'(vld), 32'd0);
    chk("t2_bad_id", 32'(id), 32'h25);
    send_frame(8'h12, 100, -1, -1);
    chk("t2_id", 32'(id), 32'h12);
    chk("t2_vld", 32'(vld), 32'd1);

    // 3b: clr on the DONE cycle loses to the set
    pulse_clr;
    send_frame(8'h2A, 100, 100 / 2 + 3, -1);
    chk("t3_done_clr_vld", 32'(vld), 32'd1);
    chk("t3_done_clr_id", 32'(id), 32'h2A);

    // 4: start + 3 bits then idle; short-timeout instance aborts
    pulse_clr;
    send_start(100);
    send_bit(1'b1, 100, -1, -1);
    send_bit(1'b0, 100, -1, -1);
    send_bit(1'b1, 100, -1, -1);
    BC = 1'b1;
    repeat (900) tick;
    chk("t4_busy_pre", 32'(busy2), 32'd1);
    chk("t4_busy_long_to", 32'(busy), 32'd1);
    repeat (100) tick;
    chk("t4_abort_busy", 32'(busy2), 32'd0);
    chk("t4_abort_vld", 32'(vld2), 32'd0);
    send_frame(8'h07, 100, -1, -1);
    chk("t4_next_id", 32'(id2), 32'h07);
    chk("t4_next_vld", 32'(vld2), 32'd1);
    pulse_rst;
    chk("t4_rst_id", 32'(id), 32'h00);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_id2", 32'(id2), 32'h00);
    chk("t4_rst_vld2", 32'(vld2), 32'd0);

    // 5a: short lows are rejected and shift nothing
    glitch(2, "t5_glitch2_busy");
    glitch(3, "t5_glitch3_busy");
    send_frame(8'h15, 100, -1, -1);
    chk("t5_after_glitch_id", 32'(id), 32'h15);
    chk("t5_after_glitch_vld", 32'(vld), 32'd1);

    // 5b: reset after bit 4 aborts the frame
    send_start(100);
    send_bit(1'b1, 100, -1, -1);
    send_bit(1'b0, 100, -1, -1);
    send_bit(1'b1, 100, -1, -1);
    send_bit(1'b1, 100, -1, -1);
    chk("t5_mid_busy", 32'(busy), 32'd1);
    pulse_rst;
    chk("t5_rst_id", 32'(id), 32'h00);
    chk("t5_rst_vld", 32'(vld), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    send_frame(8'h3F, 100, -1, -1);
    chk("t5_3f_id", 32'(id), 32'h3F);
    chk("t5_3f_vld", 32'(vld), 32'd1);

    // Shortest accepted start pulse (S = MIN_START = 4)
    send_frame(8'h2C, 8, -1, -1);
    chk("min_start_id", 32'(id), 32'h2C);

    // 6: back-to-back, no acknowledge
    send_frame(8'h01, 100, -1, -1);
    chk("t6_id1", 32'(id), 32'h01);
    send_frame(8'h02, 100, -1, -1);
    chk("t6_id2", 32'(id), 32'h02);
    chk("t6_vld", 32'(vld), 32'd1);

    // Random IDs; longest and shortest periods first, then short ones
    for (int n = 0; n < 50; n++) begin
      p   = (n == 0) ? 4096 : (n == 1) ? 64 : int'($urandom_range(64, 72));
      rid = 8'($urandom_range(0, 63));
      pulse_clr;
      send_frame(rid, p, -1, -1);
      chk("rand_vld", 32'(vld), 32'd1);
      chk("rand_id", 32'(id), 32'(rid));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
